// File: rtl/audio_decimator.sv
// Audio front stage: single-pole IIR low-pass, fractional decimation to RATE,
// 16-bit reduction, volume select and click-free soft-mute fade.
module audio_decimator #(
    parameter int CLK_HZ = 32000000,
    parameter int RATE   = 48000,
    parameter int SHIFT  = 8
) (
    input  logic               clk32_i,
    input  logic               resetn,
    input  logic               in_ce,
    input  logic signed [17:0] audio_l,
    input  logic signed [17:0] audio_r,
    input  logic        [1:0]  volume,
    input  logic               mute_req,
    output logic signed [15:0] audio_out_l,
    output logic signed [15:0] audio_out_r,
    output logic               sample_strobe,
    output logic               muted
);
    localparam int YW = 18 + SHIFT + 1;

    typedef enum logic [1:0] {S_MUTED, S_FADE_IN, S_RUN, S_FADE_OUT} state_t;

    function automatic logic signed [YW-1:0] iir_step(input logic signed [YW-1:0] y,
                                                      input logic signed [17:0]   x);
        logic signed [YW-1:0] x_ext;
        x_ext = {{(YW-18){x[17]}}, x};
        return y + x_ext - (y >>> SHIFT);
    endfunction

    // Filter output f = y >>> SHIFT, then a further >>> 2 down to 16 bits.
    function automatic logic signed [15:0] reduce16(input logic signed [YW-1:0] y);
        return 16'(y >>> (SHIFT + 2));
    endfunction

    function automatic logic signed [15:0] apply_gain(input logic signed [15:0] s,
                                                      input logic        [4:0]  gain,
                                                      input logic        [1:0]  vol);
        logic signed [20:0] p;
        logic signed [20:0] g;
        logic signed [15:0] res;
        p = 21'(s) * $signed({16'd0, gain});
        g = p >>> 4;
        case (vol)
            2'd0:    res = '0;
            2'd1:    res = 16'(g >>> 2);
            2'd2:    res = 16'(g >>> 1);
            default: res = 16'(g);
        endcase
        return res;
    endfunction

    logic        [31:0]    r_acc;
    logic        [32:0]    w_acc_sum;
    logic                  w_tick;
    logic signed [YW-1:0]  r_y_l;
    logic signed [YW-1:0]  r_y_r;
    logic signed [YW-1:0]  w_y_l_nxt;
    logic signed [YW-1:0]  w_y_r_nxt;
    state_t                r_state;
    state_t                w_state_nxt;
    logic        [4:0]     r_gain;
    logic        [4:0]     w_gain_nxt;

    assign w_acc_sum = {1'b0, r_acc} + 33'(RATE);
    assign w_tick    = (w_acc_sum >= 33'(CLK_HZ));

    // The tick cycle's own in_ce sample is included in the output word.
    assign w_y_l_nxt = in_ce ? iir_step(r_y_l, audio_l) : r_y_l;
    assign w_y_r_nxt = in_ce ? iir_step(r_y_r, audio_r) : r_y_r;

    always_ff @(posedge clk32_i or negedge resetn) begin
        if (!resetn) begin
            r_acc <= '0;
            r_y_l <= '0;
            r_y_r <= '0;
        end else begin
            r_acc <= w_tick ? 32'(w_acc_sum - 33'(CLK_HZ)) : w_acc_sum[31:0];
            r_y_l <= w_y_l_nxt;
            r_y_r <= w_y_r_nxt;
        end
    end

    always_ff @(posedge clk32_i or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_MUTED;
            r_gain  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
        end
    end

    // Reversals mid-fade keep the gain for one tick; endpoints saturate at 0 and 16.
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                S_MUTED:    if (!mute_req) w_state_nxt = S_FADE_IN;
                S_FADE_IN:  if (mute_req) w_state_nxt = S_FADE_OUT;
                            else if (r_gain >= 5'd15) w_state_nxt = S_RUN;
                S_RUN:      if (mute_req) w_state_nxt = S_FADE_OUT;
                default:    if (!mute_req) w_state_nxt = S_FADE_IN;
                            else if (r_gain <= 5'd1) w_state_nxt = S_MUTED;
            endcase
        end
    end

    always_comb begin
        w_gain_nxt = r_gain;
        if (w_tick) begin
            case (r_state)
                S_MUTED:    w_gain_nxt = 5'd0;
                S_FADE_IN:  if (!mute_req) w_gain_nxt = (r_gain >= 5'd15) ? 5'd16 : r_gain + 5'd1;
                S_RUN:      w_gain_nxt = 5'd16;
                default:    if (mute_req) w_gain_nxt = (r_gain <= 5'd1) ? 5'd0 : r_gain - 5'd1;
            endcase
        end
    end

    always_ff @(posedge clk32_i or negedge resetn) begin
        if (!resetn) begin
            audio_out_l   <= '0;
            audio_out_r   <= '0;
            sample_strobe <= 1'b0;
            muted         <= 1'b1;
        end else begin
            sample_strobe <= w_tick;
            if (w_tick) begin
                audio_out_l <= apply_gain(reduce16(w_y_l_nxt), r_gain, volume);
                audio_out_r <= apply_gain(reduce16(w_y_r_nxt), r_gain, volume);
                muted       <= (w_state_nxt == S_MUTED);
            end
        end
    end
endmodule
